// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full / almost-empty
// thresholds, feeding the flow-control state machine.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   umbral_alto           free-slot threshold: almost_full = count >= DEPTH - umbral_alto
//   umbral_bajo           occupancy threshold: almost_empty = count <= umbral_bajo
//   push, data_in         write request and data
//   pop                   read request
//   data_out, valid_out   registered read data, valid the cycle after a pop
//   fifo_empty/fifo_full  count == 0 / count == DEPTH
//   almost_full/almost_empty  threshold flags (combinational from count)
//   fifo_error            registered overflow/underflow flag
//   count                 words stored, 0..DEPTH
//
// Configuration macro FIFO_ERR_STICKY_EN: when defined, fifo_error holds at 1
// after the first error until reset; otherwise it pulses once per error event.

module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned           DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_error;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;
    logic w_err_evt;

    always_comb begin
        w_full    = (r_count == C_DEPTH);
        w_empty   = (r_count == '0);
        // A push while full is accepted only when a pop frees the slot in the same cycle.
        w_wr      = push && (!w_full || pop);
        w_rd      = pop && !w_empty;
        w_err_evt = (push && w_full && !pop) || (pop && w_empty);
    end

    // Storage has no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && w_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            // When full with push+pop, wr_ptr == rd_ptr; the read sees the old word
            // because the memory write lands at the same edge.
            if (w_rd) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - (ADDR_WIDTH+1)'(1);
            end
`ifdef FIFO_ERR_STICKY_EN
            r_error <= r_error | w_err_evt;
`else
            r_error <= w_err_evt;
`endif
        end
    end

    always_comb begin
        data_out     = r_data_out;
        valid_out    = r_valid;
        fifo_error   = r_error;
        count        = r_count;
        fifo_empty   = w_empty;
        fifo_full    = w_full;
        // Thresholds are zero-extended so the subtraction cannot wrap.
        almost_full  = (r_count >= (C_DEPTH - {1'b0, umbral_alto}));
        almost_empty = (r_count <= {1'b0, umbral_bajo});
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed bench for fifo_umbral with a queue-based reference
// model compared on every negative clock edge, plus literal spot checks.

module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic [1:0] umbral_alto;
    logic [1:0] umbral_bajo;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_error;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the registered outputs.
    logic [5:0] m_q [$];
    logic [5:0] m_dout  = '0;
    bit         m_valid = 0;
    bit         m_err   = 0;

    always @(posedge clk) begin
        int  n;
        bit  full_now;
        bit  empty_now;
        bit  evt;
        if (reset) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 0;
            m_err   = 0;
        end else begin
            n         = m_q.size();
            full_now  = (n == 4);
            empty_now = (n == 0);
            evt       = (push && full_now && !pop) || (pop && empty_now);
            if (pop && !empty_now) begin
                m_dout  = m_q.pop_front();
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (push && !(full_now && !pop)) m_q.push_back(data_in);
            m_err = STICKY ? (m_err | evt) : evt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = m_q.size();
            check("count",        32'(count),        32'(n));
            check("fifo_empty",   32'(fifo_empty),   32'(n == 0));
            check("fifo_full",    32'(fifo_full),    32'(n == 4));
            check("almost_full",  32'(almost_full),  32'(n >= 4 - int'(umbral_alto)));
            check("almost_empty", 32'(almost_empty), 32'(n <= int'(umbral_bajo)));
            check("valid_out",    32'(valid_out),    32'(m_valid));
            check("data_out",     32'(data_out),     32'(m_dout));
            check("fifo_error",   32'(fifo_error),   32'(m_err));
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic step(input bit ps, input bit pp, input logic [5:0] d);
        push    = ps;
        pop     = pp;
        data_in = d;
        @(posedge clk);
        #1;
        push = 0;
        pop  = 0;
    endtask

    initial begin
        reset       = 1;
        umbral_alto = 2'd1;
        umbral_bajo = 2'd0;
        push        = 0;
        pop         = 0;
        data_in     = '0;

        // 1 Reset
        step(0, 0, '0);
        step(0, 0, '0);
        chk_en = 1;
        check("rst_count",  32'(count),        32'd0);
        check("rst_empty",  32'(fifo_empty),   32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full",   32'(fifo_full),    32'd0);
        check("rst_err",    32'(fifo_error),   32'd0);
        check("rst_valid",  32'(valid_out),    32'd0);
        check("rst_dout",   32'(data_out),     32'd0);
        reset = 0;

        // 2 Fill and drain, three rounds for pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) begin
                step(1, 0, 6'(i));
                check("fill_afull", 32'(almost_full), 32'(i >= 3));
                check("fill_full",  32'(fifo_full),   32'(i == 4));
            end
            for (int i = 1; i <= 4; i++) begin
                step(0, 1, '0);
                check("drain_dout",  32'(data_out),  32'(i));
                check("drain_valid", 32'(valid_out), 32'd1);
            end
            step(0, 0, '0);
            check("idle_valid", 32'(valid_out), 32'd0);
        end

        // 3 Overflow
        for (int i = 1; i <= 4; i++) step(1, 0, 6'(i));
        step(1, 0, 6'h2A);
        check("ovf_err",   32'(fifo_error), 32'd1);
        check("ovf_count", 32'(count),      32'd4);
        step(0, 0, '0);
        check("ovf_err_after", 32'(fifo_error), 32'(STICKY));
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, '0);
            check("ovf_drain", 32'(data_out), 32'(i));
        end

        // 4 Underflow
        step(0, 1, '0);
        check("unf_valid", 32'(valid_out),  32'd0);
        check("unf_count", 32'(count),      32'd0);
        check("unf_err",   32'(fifo_error), 32'd1);

        // 5 Simultaneous push+pop when full and when empty
        for (int i = 1; i <= 4; i++) step(1, 0, 6'(8'h10 + i));
        step(1, 1, 6'h15);
        check("pp_full_dout",  32'(data_out),   32'h11);
        check("pp_full_count", 32'(count),      32'd4);
        check("pp_full_err",   32'(fifo_error), 32'(STICKY));
        for (int i = 2; i <= 5; i++) begin
            step(0, 1, '0);
            check("pp_drain", 32'(data_out), 32'(8'h10 + i));
        end
        step(1, 1, 6'h07);
        check("pp_empty_count", 32'(count),      32'd1);
        check("pp_empty_valid", 32'(valid_out),  32'd0);
        check("pp_empty_err",   32'(fifo_error), 32'd1);
        step(0, 1, '0);
        check("pp_empty_dout", 32'(data_out), 32'h07);

        // 6 Threshold sweep at count=2, then reset mid-operation
        step(1, 0, 6'h21);
        step(1, 0, 6'h22);
        for (int b = 0; b < 4; b++) begin
            umbral_bajo = 2'(b);
            #1;
            check("sweep_aempty", 32'(almost_empty), 32'(b >= 2));
        end
        umbral_alto = 2'd0;
        #1;
        check("alto0_afull", 32'(almost_full), 32'(fifo_full));
        step(0, 0, '0);
        reset = 1;
        step(1, 1, 6'h33);
        reset = 0;
        check("midrst_count", 32'(count),      32'd0);
        check("midrst_err",   32'(fifo_error), 32'd0);
        step(0, 1, '0);
        check("midrst_unf_err",   32'(fifo_error), 32'd1);
        check("midrst_unf_valid", 32'(valid_out),  32'd0);

        // Mixed traffic with varying thresholds, checked by the model only
        for (int k = 0; k < 200; k++) begin
            umbral_alto = 2'($urandom_range(0, 3));
            umbral_bajo = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        end
        step(0, 0, '0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
